// File: rtl/seg_scan_reader.sv
// Receive side of the multiplexed 7-segment display bus.
// Synchronizes the segment and digit-select lines, waits for each digit window to
// hold a constant pattern for STABLE_CYC samples, decodes it back to a 4-bit code,
// and stores one code per digit. A one-cycle frame strobe marks a completed scan.
module seg_scan_reader #(
    parameter int unsigned DIGITS         = 6,
    parameter int unsigned STABLE_CYC     = 4,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     sel_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid
);

    // XOR mask that normalises select to active-high; also the idle level of sel_in.
    localparam logic [DIGITS-1:0] SelInvert = {DIGITS{SEL_ACTIVE_LOW}};
    localparam logic [7:0]        CntLast   = 8'(STABLE_CYC - 1);
    localparam logic [7:0]        CntMax    = 8'(STABLE_CYC);

    typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

    // Decoded result: {err, code}
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b0111111: res = {1'b0, 4'd0};
            7'b0000110: res = {1'b0, 4'd1};
            7'b1011011: res = {1'b0, 4'd2};
            7'b1001111: res = {1'b0, 4'd3};
            7'b1100110: res = {1'b0, 4'd4};
            7'b1101101: res = {1'b0, 4'd5};
            7'b1111101: res = {1'b0, 4'd6};
            7'b0000111: res = {1'b0, 4'd7};
            7'b1111111: res = {1'b0, 4'd8};
            7'b1101111: res = {1'b0, 4'd9};
            7'b0000000: res = {1'b0, 4'hF};
            default:    res = {1'b1, 4'hE};
        endcase
        return res;
    endfunction

    logic [6:0]          seg_s1_q, seg_s2_q;
    logic [DIGITS-1:0]   sel_s1_q, sel_s2_q;
    logic [6:0]          seg_prev_q;
    logic [DIGITS-1:0]   sel_prev_q;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic                frame_q, frame_d;

    logic [DIGITS-1:0]   sel_norm;
    logic                sel_valid;
    logic                pair_changed;
    logic                capture;
    logic [4:0]          dec;

    // Two-flop synchronizers plus a copy of the previous synchronized pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q   <= '0;
            seg_s2_q   <= '0;
            seg_prev_q <= '0;
            sel_s1_q   <= SelInvert;
            sel_s2_q   <= SelInvert;
            sel_prev_q <= SelInvert;
        end else begin
            seg_s1_q   <= seg_in;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            sel_s1_q   <= sel_in;
            sel_s2_q   <= sel_s1_q;
            sel_prev_q <= sel_s2_q;
        end
    end

    assign sel_norm     = sel_s2_q ^ SelInvert;
    assign sel_valid    = $onehot(sel_norm);
    assign pair_changed = (seg_s2_q != seg_prev_q) || (sel_s2_q != sel_prev_q);
    assign dec          = decode_seg(seg_s2_q);

    // Settle/capture FSM and per-digit storage next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        mask_d  = mask_q;
        frame_d = 1'b0;
        capture = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    state_d = StSettle;
                    cnt_d   = 8'd1;
                end
            end
            StSettle: begin
                if (!sel_valid) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (pair_changed) begin
                    cnt_d = 8'd1;
                end else if (cnt_q == CntLast) begin
                    capture = 1'b1;
                    cnt_d   = CntMax;
                    state_d = StHeld;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHeld: begin
                if (!sel_valid) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (pair_changed) begin
                    state_d = StSettle;
                    cnt_d   = 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase

        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_norm[i]) begin
                    bcd_d[4*i +: 4] = dec[3:0];
                    err_d[i]        = dec[4];
                    mask_d[i]       = 1'b1;
                end
            end
            // Last missing digit completes the frame; mask restarts on the same edge.
            if (&mask_d) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            bcd_q   <= '1;
            err_q   <= '0;
            mask_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            frame_q <= frame_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_err   = err_q;
    assign frame_valid = frame_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Self-checking bench for seg_scan_reader: directed scenarios plus random scanning,
// compared every cycle against a run-length reference model.
module tb_seg_scan_reader;

    localparam int DIGITS     = 6;
    localparam int STABLE_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [5:0]  sel_in;
    logic [23:0] bcd_out;
    logic [5:0]  digit_err;
    logic        frame_valid;

    seg_scan_reader #(
        .DIGITS         (DIGITS),
        .STABLE_CYC     (STABLE_CYC),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .sel_in      (sel_in),
        .bcd_out     (bcd_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111};

    // Reference model state
    logic [3:0] m_bcd [DIGITS];
    logic [5:0] m_err;
    logic [5:0] m_mask;
    logic       m_fv;
    int         m_run;
    logic [5:0] p1_sel, p2_sel, pv_sel;
    logic [6:0] p1_seg, p2_seg, pv_seg;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] sel_for(input int d);
        logic [5:0] one;
        one = 6'd1 << d;
        return ~one;
    endfunction

    task automatic ref_decode(input logic [6:0] seg, output logic [3:0] code, output logic err);
        if (seg == 7'd0) begin
            code = 4'hF;
            err  = 1'b0;
        end else begin
            code = 4'hE;
            err  = 1'b1;
            for (int v = 0; v < 10; v++) begin
                if (seg_tab[v] == seg) begin
                    code = 4'(v);
                    err  = 1'b0;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) m_bcd[i] = 4'hF;
        m_err  = '0;
        m_mask = '0;
        m_fv   = 1'b0;
        m_run  = 0;
        p1_sel = 6'h3F; p2_sel = 6'h3F; pv_sel = 6'h3F;
        p1_seg = '0;    p2_seg = '0;    pv_seg = '0;
    endtask

    // One clock edge: the decision uses the input sampled two edges earlier.
    task automatic model_edge(input logic [5:0] sel, input logic [6:0] seg);
        logic [5:0] norm;
        logic       valid;
        int         idx;
        logic [3:0] code;
        logic       err;
        norm  = ~p2_sel;
        valid = ($countones(norm) == 1);
        if (!valid) m_run = 0;
        else if (m_run > 0 && p2_sel == pv_sel && p2_seg == pv_seg) m_run++;
        else m_run = 1;
        m_fv = 1'b0;
        if (valid && m_run == STABLE_CYC) begin
            idx = 0;
            for (int i = 0; i < DIGITS; i++) if (norm[i]) idx = i;
            ref_decode(p2_seg, code, err);
            m_bcd[idx]  = code;
            m_err[idx]  = err;
            m_mask[idx] = 1'b1;
            if (&m_mask) begin
                m_fv   = 1'b1;
                m_mask = '0;
            end
        end
        pv_sel = p2_sel; pv_seg = p2_seg;
        p2_sel = p1_sel; p2_seg = p1_seg;
        p1_sel = sel;    p1_seg = seg;
    endtask

    function automatic logic [23:0] model_bcd();
        logic [23:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = m_bcd[i];
        return v;
    endfunction

    // Called at a negedge: drive, clock once, compare #1 after the edge, return at negedge.
    task automatic cycle(input logic [5:0] sel, input logic [6:0] seg);
        sel_in = sel;
        seg_in = seg;
        @(posedge clk);
        model_edge(sel, seg);
        #1;
        check_eq("bcd_out", 32'(bcd_out), 32'(model_bcd()));
        check_eq("digit_err", 32'(digit_err), 32'(m_err));
        check_eq("frame_valid", 32'(frame_valid), 32'(m_fv));
        if (frame_valid === 1'b1) pulses++;
        @(negedge clk);
    endtask

    task automatic random_segments(input int count);
        int r, d, v, n;
        logic [5:0] s;
        logic [6:0] p;
        repeat (count) begin
            r = $urandom_range(0, 99);
            d = $urandom_range(0, DIGITS - 1);
            s = sel_for(d);
            if (r < 5) s = 6'h3F;
            else if (r < 10) s = sel_for(d) & sel_for((d + 1) % DIGITS);
            v = $urandom_range(0, 99);
            if (v < 70) p = seg_tab[$urandom_range(0, 9)];
            else if (v < 80) p = 7'd0;
            else p = 7'($urandom);
            n = $urandom_range(1, 9);
            repeat (n) cycle(s, p);
        end
    endtask

    initial begin
        logic [5:0] s;
        rst_n  = 1'b0;
        sel_in = 6'h3F;
        seg_in = 7'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_bcd", 32'(bcd_out), 32'h00FFFFFF);
        check_eq("rst_err", 32'(digit_err), 32'h0);
        check_eq("rst_fv", 32'(frame_valid), 32'h0);
        rst_n = 1'b1;

        // Latency: applied before edge k, code appears after edge k+5.
        for (int i = 0; i <= 5; i++) begin
            cycle(6'b111110, 7'b1011011);
            if (i < 5) check_eq("lat_early", 32'(bcd_out[3:0]), 32'hF);
            else       check_eq("lat_capture", 32'(bcd_out[3:0]), 32'd2);
        end
        repeat (4) cycle(6'b111110, 7'b1011011);
        check_eq("lat_no_frame", 32'(pulses), 32'd0);

        // Reset mid-run with inputs toggling.
        random_segments(6);
        sel_in = 6'b111101;
        seg_in = seg_tab[3];
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_bcd", 32'(bcd_out), 32'h00FFFFFF);
        check_eq("midrst_err", 32'(digit_err), 32'h0);
        check_eq("midrst_fv", 32'(frame_valid), 32'h0);
        model_reset();
        #1 rst_n = 1'b1;

        // Two full scans, one pulse each.
        for (int scan = 0; scan < 2; scan++) begin
            pulses = 0;
            for (int d = 0; d < DIGITS; d++) begin
                s = sel_for(d);
                repeat (8) cycle(s, seg_tab[d + 1]);
                cycle(6'h3F, 7'd0);
            end
            repeat (3) cycle(6'h3F, 7'd0);
            check_eq("frame_bcd", 32'(bcd_out), 32'h00654321);
            check_eq("frame_err", 32'(digit_err), 32'h0);
            check_eq("frame_pulses", 32'(pulses), 32'd1);
        end

        // Glitch reject: short 8 followed by a held 7.
        s = sel_for(2);
        repeat (3) cycle(s, 7'b1111111);
        repeat (10) begin
            cycle(s, 7'b0000111);
            check_eq("glitch_no8", 32'(bcd_out[11:8] == 4'd8), 32'd0);
        end
        check_eq("glitch_d2", 32'(bcd_out[11:8]), 32'd7);

        // Bad, valid, then blank pattern on digit 3.
        s = sel_for(3);
        repeat (8) cycle(s, 7'b0000001);
        check_eq("bad_code", 32'(bcd_out[15:12]), 32'hE);
        check_eq("bad_err", 32'(digit_err[3]), 32'd1);
        repeat (8) cycle(s, 7'b0000111);
        check_eq("fix_code", 32'(bcd_out[15:12]), 32'd7);
        check_eq("fix_err", 32'(digit_err[3]), 32'd0);
        repeat (8) cycle(s, 7'b0000000);
        check_eq("blank_code", 32'(bcd_out[15:12]), 32'hF);
        check_eq("blank_err", 32'(digit_err[3]), 32'd0);

        // Invalid selects never capture.
        pulses = 0;
        for (int i = 0; i < 20; i++) cycle((i % 2 == 0) ? 6'b111100 : 6'b111111, 7'($urandom));
        check_eq("inv_bcd", 32'(bcd_out), 32'h0065F721);
        check_eq("inv_pulses", 32'(pulses), 32'd0);

        random_segments(250);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
Receive side of the team's multiplexed 7-segment display bus. Samples the shared segment lines and per-digit select lines, waits for each digit window to settle, and converts the segment pattern back to a 4-bit code. Keeps one code register per digit and pulses a frame strobe once every digit has been captured. Used for loop-back checking of the display path and for reading external 7-segment panels.

Parameters:
DIGITS, 6, number of multiplexed digits (width of sel_in); 1..8.
STABLE_CYC, 4, consecutive identical synchronized samples required before capture; 2..255.
SEL_ACTIVE_LOW, 1, 1: a digit is selected when its sel_in bit is 0; 0: selected when the bit is 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
seg_in  input  7  segment lines a..g on bits 0..6, active-high; asynchronous to clk
sel_in  input  DIGITS  digit select lines, polarity set by SEL_ACTIVE_LOW; asynchronous to clk
bcd_out  output  4*DIGITS  captured code per digit; digit i occupies bits [4i+3:4i]
digit_err  output  DIGITS  1 = the last capture for digit i was an unrecognised pattern
frame_valid  output  1  one-cycle pulse when all digits have been captured since the previous pulse

Behaviour:
- Reset (async assert, sync release): bcd_out all 4'hF, digit_err 0, frame_valid 0, captured-mask 0, state IDLE, stability counter 0. Synchronizer flops load 0 for seg and the inactive level for sel. Reset mid-operation takes effect immediately; a partial frame is discarded.
- Input sync: seg_in and sel_in each pass through 2 flops. Internally sel is normalised to active-high.
- Select is valid only when exactly one normalised bit is set. Zero or multiple bits set means idle.
- States:
  - IDLE: select not valid; counter 0. Go to SETTLE when a valid select appears (counter = 1).
  - SETTLE: counter increments each edge while the synchronized (sel, seg) pair is unchanged. Any change in the pair restarts counting at 1 with the new pair; an invalid select returns to IDLE. When the counter would reach STABLE_CYC, capture on that edge and go to HELD.
  - HELD: no further capture. A change of seg with the same sel goes to SETTLE (count 1), so a display update is recaptured. A change of sel goes to SETTLE with the new digit, or to IDLE if the select is invalid.
- Latency: inputs constant from before edge k: the synchronized value is present after edge k+1, and capture occurs at edge k+1+STABLE_CYC. With defaults, bcd_out is updated after edge k+5.
- Decode table (bits g..a):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - 0000000 = blank: code 4'hF, err 0.
  - Any other pattern: code 4'hE, err 1.
  - A valid or blank capture clears that digit's err bit.
- On capture: write the code and err for the selected digit only, and set its mask bit. Recapturing an already-set digit overwrites it; the mask is unchanged.
- Frame:
  - On the capture edge where the mask becomes all ones, frame_valid is registered high for exactly one cycle and the mask clears on the same edge.
  - Scan order is irrelevant.
  - frame_valid never asserts on consecutive cycles (each capture needs at least STABLE_CYC edges).
- The counter saturates and never wraps; a held pattern captures once only.

Test Plan:
- Reset: assert rst_n=0 mid-run with inputs toggling -> bcd_out=24'hFFFFFF, digit_err=0, frame_valid=0 immediately, without waiting for a clk edge.
- Latency: sel_in=6'b111110, seg_in=7'b1011011 applied before edge k and held -> bcd_out[3:0] still 4'hF after edge k+4 and 4'd2 after edge k+5; frame_valid stays 0.
- Full frame: scan digits 0..5 showing 1,2,3,4,5,6, each held 8 cycles with 1 cycle of all-off between -> bcd_out=24'h654321, frame_valid high exactly 1 cycle after the digit 5 capture, digit_err=0. A second identical scan gives a second single pulse.
- Glitch reject: digit 2 pattern 7'b1111111 held 3 cycles, then changed to 7'b0000111 and held 10 cycles -> digit 2 reads 4'd7, never 4'd8.
- Bad/blank patterns: digit 3 shows 7'b0000001 -> bcd 4'hE, digit_err[3]=1. Then 7'b0000111 -> 4'd7, err[3]=0. Then 7'b0000000 -> 4'hF, err[3]=0.
- Invalid select: sel_in=6'b111100 or 6'b111111 for 20 cycles with any seg -> no bcd_out change, no mask change, no frame_valid.
